pll_reset_sequencer: RTL
========================

// Module: pll_reset_sequencer
// PURPOSE
//  Supervises a multi-output PLL and sequences per-domain resets.
//  - Pulses the PLL reset and waits for lock, retrying on timeout.
//  - Debounces lock, then releases NUM_CLOCKS domain resets one at a time, in
//    order, with a fixed stagger between them.
//  - Runs on the free-running board reference clock. Sits between the PLL
//    wrapper and the per-domain reset synchronisers.
// PARAMETERS
//  NUM_CLOCKS      4     number of PLL output domains / reset channels (1..18)
//  PLL_RST_CYCLES  16    refclk cycles pll_rst is held high per attempt (>=1)
//  LOCK_TIMEOUT    50000 refclk cycles to wait for lock per attempt (>=2)
//  LOCK_STABLE     1024  consecutive locked cycles required before any release (>=1)
//  STAGGER         64    refclk cycles between successive channel releases (>=1)
//  MAX_RETRY       3     lock-timeout retries before declaring failure (0..15)
// PORTS
//  refclk      in   1           reference clock (free running)
//  rst_n       in   1           asynchronous, active-low reset
//  restart     in   1           sync pulse: restart the full sequence
//  pll_locked  in   1           PLL lock, asynchronous; 2-FF synchronised internally
//  pll_rst     out  1           active-high reset to the PLL
//  clk_rst_n   out  NUM_CLOCKS  per-domain resets, active low; bit i = outclk_i
//  ready       out  1           all domains released and lock held
//  fail        out  1           retries exhausted; sticky until restart or rst_n
//  retry_cnt   out  4           timeouts consumed in the current sequence
// BEHAVIOUR
//  - Reset values (rst_n low): pll_rst=1, clk_rst_n=0, ready=0, fail=0,
//    retry_cnt=0, state=PLLRST, all counters 0.
//  - All outputs are registered.
//  - locked_s is pll_locked after the 2-FF synchroniser (2-cycle latency).
//  - States and transitions:
//    - PLLRST: pll_rst=1 for exactly PLL_RST_CYCLES cycles, then WAIT_LOCK.
//    - WAIT_LOCK: pll_rst=0, timer counts.
//      - locked_s=1 -> STABLE.
//      - Timer reaches LOCK_TIMEOUT-1 with no lock:
//        - retry_cnt==MAX_RETRY -> FAIL;
//        - otherwise retry_cnt++ -> PLLRST.
//    - STABLE: needs LOCK_STABLE consecutive cycles of locked_s=1, then RELEASE.
//      - locked_s=0 -> WAIT_LOCK. Timer restarts; no retry is consumed.
//    - RELEASE: clk_rst_n[i] goes high (i+1)*STAGGER cycles after entry,
//      i = 0..NUM_CLOCKS-1.
//      - Enter RUN on the same cycle the last bit is released.
//    - RUN: ready=1.
//    - FAIL: pll_rst=1, fail=1, clk_rst_n=0. Held until restart or rst_n.
//  - Lock loss in RELEASE or RUN (locked_s 1->0):
//    - next cycle: clk_rst_n=0 (all bits), ready=0, state -> PLLRST;
//    - retry_cnt is cleared, because a lock loss is not a timeout.
//  - restart=1 in any state: next cycle state=PLLRST, clk_rst_n=0, ready=0,
//    fail=0, retry_cnt=0, counters cleared.
//    - restart takes priority over every other simultaneous event.
//  - Channel release is monotonic inside RELEASE/RUN. No bit is deasserted
//    except by lock loss, restart or rst_n, and those deassert all bits together.
//  - Counter widths are $clog2(max value + 1). No wrap is reachable.
//  - The debounce counter saturates.
//  - rst_n asserted mid-sequence: immediate return to reset values, no glitch
//    on clk_rst_n (it is already 0 or goes to 0).
// CONFIGURATION
//  - Macro PLL_LOSS_COUNTER_EN:
//    - Defined: extra output port loss_cnt [7:0], reset value 0.
//      - Increments by 1 on each lock loss detected in RELEASE or RUN.
//      - Saturates at 255. Cleared only by rst_n; restart does not clear it.
//    - Undefined: the port and its logic are absent; all other behaviour is identical.
// TESTING
//  Bench parameters: NUM_CLOCKS=4, PLL_RST_CYCLES=8, LOCK_TIMEOUT=100,
//  LOCK_STABLE=16, STAGGER=4, MAX_RETRY=2.
//  1. Lock rises 10 cycles after pll_rst falls, then stays high
//     -> pll_rst high for exactly 8 cycles
//     -> bits 0..3 of clk_rst_n rise in order, 4 cycles apart, the first
//        16+4 cycles after locked_s
//     -> ready=1 with clk_rst_n=4'hF.
//  2. pll_locked held low -> three pll_rst pulses, retry_cnt 0,1,2
//     -> fail=1 and pll_rst=1 after the third 100-cycle timeout
//     -> restart pulse clears fail and retry_cnt to 0.
//  3. Lock glitches low for 1 cycle at debounce count 10
//     -> no release, no pll_rst pulse
//     -> release starts only after a fresh run of 16 locked cycles.
//  4. Lock lost in RUN -> clk_rst_n=0 and ready=0 one cycle after locked_s
//     falls -> new 8-cycle pll_rst pulse; loss_cnt=1 when the macro is defined.
//  5. restart asserted on the same cycle as lock loss and during RELEASE
//     (2 bits released) -> restart wins, all bits 0, retry_cnt=0.
//  6. rst_n asserted during STABLE and during RUN -> all outputs at reset
//     values asynchronously.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock supervisor with debounced, staggered per-domain reset release.
// Define PLL_LOSS_COUNTER_EN to add the saturating loss_cnt output.
module pll_reset_sequencer #(
  parameter int NUM_CLOCKS     = 4,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int LOCK_STABLE    = 1024,
  parameter int STAGGER        = 64,
  parameter int MAX_RETRY      = 3
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  restart,
  input  logic                  pll_locked,
  output logic                  pll_rst,
  output logic [NUM_CLOCKS-1:0] clk_rst_n,
  output logic                  ready,
  output logic                  fail,
  output logic [3:0]            retry_cnt
`ifdef PLL_LOSS_COUNTER_EN
  ,
  output logic [7:0]            loss_cnt
`endif
);

  localparam logic [2:0] S_PLLRST  = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_STABLE  = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_RUN     = 3'd4;
  localparam logic [2:0] S_FAIL    = 3'd5;

  localparam int RW = $clog2(PLL_RST_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int DW = $clog2(LOCK_STABLE + 1);
  localparam int SW = $clog2(STAGGER + 1);
  localparam int CW = $clog2(NUM_CLOCKS + 1);

  localparam logic [RW-1:0] RST_LAST = RW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [DW-1:0] DBN_LAST = DW'(LOCK_STABLE - 1);
  localparam logic [DW-1:0] DBN_MAX  = DW'(LOCK_STABLE);
  localparam logic [SW-1:0] STG_LAST = SW'(STAGGER - 1);
  localparam logic [CW-1:0] CH_LAST  = CW'(NUM_CLOCKS - 1);
  localparam logic [3:0]    RTY_MAX  = 4'(MAX_RETRY);
  localparam logic [NUM_CLOCKS-1:0] CH_ONE = NUM_CLOCKS'(1);

  logic [2:0]    state;
  logic          sync1;
  logic          locked_s;
  logic [RW-1:0] rst_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [DW-1:0] dbn_cnt;
  logic [SW-1:0] stg_cnt;
  logic [CW-1:0] ch_idx;
  logic          lost;

  assign lost = ((state == S_RELEASE) || (state == S_RUN)) && !locked_s;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= pll_locked;
      locked_s <= sync1;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_PLLRST;
      pll_rst   <= 1'b1;
      clk_rst_n <= '0;
      ready     <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
      rst_cnt   <= '0;
      tmo_cnt   <= '0;
      dbn_cnt   <= '0;
      stg_cnt   <= '0;
      ch_idx    <= '0;
    end else if (restart || lost) begin
      state     <= S_PLLRST;
      pll_rst   <= 1'b1;
      clk_rst_n <= '0;
      ready     <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
      rst_cnt   <= '0;
      tmo_cnt   <= '0;
      dbn_cnt   <= '0;
      stg_cnt   <= '0;
      ch_idx    <= '0;
    end else begin
      unique case (state)
        S_PLLRST: begin
          if (rst_cnt == RST_LAST) begin
            state   <= S_WAIT;
            pll_rst <= 1'b0;
            rst_cnt <= '0;
            tmo_cnt <= '0;
          end else begin
            rst_cnt <= rst_cnt + RW'(1);
          end
        end
        S_WAIT: begin
          // the lock-detect cycle is the first of the stable run
          if (locked_s) begin
            state   <= S_STABLE;
            dbn_cnt <= DW'(1);
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_cnt <= '0;
            pll_rst <= 1'b1;
            if (retry_cnt == RTY_MAX) begin
              state <= S_FAIL;
              fail  <= 1'b1;
            end else begin
              state     <= S_PLLRST;
              retry_cnt <= retry_cnt + 4'd1;
              rst_cnt   <= '0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        S_STABLE: begin
          if (!locked_s) begin
            state   <= S_WAIT;
            tmo_cnt <= '0;
            dbn_cnt <= '0;
          end else if (dbn_cnt == DBN_LAST || dbn_cnt == DBN_MAX) begin
            state   <= S_RELEASE;
            stg_cnt <= '0;
            ch_idx  <= '0;
          end else begin
            dbn_cnt <= dbn_cnt + DW'(1);
          end
        end
        S_RELEASE: begin
          if (stg_cnt == STG_LAST) begin
            stg_cnt   <= '0;
            clk_rst_n <= clk_rst_n | (CH_ONE << ch_idx);
            ch_idx    <= ch_idx + CW'(1);
            if (ch_idx == CH_LAST) begin
              state <= S_RUN;
              ready <= 1'b1;
            end
          end else begin
            stg_cnt <= stg_cnt + SW'(1);
          end
        end
        S_RUN: begin
        end
        S_FAIL: begin
        end
        default: begin
          state   <= S_PLLRST;
          pll_rst <= 1'b1;
        end
      endcase
    end
  end

`ifdef PLL_LOSS_COUNTER_EN
  // a loss coinciding with restart is absorbed by the restart
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt <= '0;
    end else if (lost && !restart && loss_cnt != 8'hFF) begin
      loss_cnt <= loss_cnt + 8'd1;
    end
  end
`endif

endmodule
